// File: rtl/bar_timer_ctrl.sv
// Top-of-screen timer bar sequencer: shrinks the bar once every few frames, refills on request,
// and picks the bar colour (normal, blinking warning, expired). All outputs are registered.
module bar_timer_ctrl #(
  parameter int unsigned BAR_MAX_WIDTH    = 640,
  parameter int unsigned FRAMES_PER_PIXEL = 4,
  parameter int unsigned REFILL_PIXELS    = 64,
  parameter int unsigned WARN_WIDTH       = 80,
  parameter int unsigned BLINK_FRAMES     = 8,
  parameter logic [7:0]  NORMAL_COLOR     = 8'h88,
  parameter logic [7:0]  WARN_COLOR       = 8'hE0
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        start,
  input  logic        pause,
  input  logic        refill,
  output logic [10:0] barWidth,
  output logic [7:0]  barColor,
  output logic        running,
  output logic        expired
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StExpired} state_e;

  localparam logic [10:0] MaxW      = 11'(BAR_MAX_WIDTH);
  localparam logic [11:0] RefillAdd = 12'(REFILL_PIXELS);
  localparam logic [11:0] WarnW     = 12'(WARN_WIDTH);
  localparam logic [15:0] FppLast   = 16'(FRAMES_PER_PIXEL - 1);
  localparam logic [15:0] BlinkLast = 16'(BLINK_FRAMES - 1);

  state_e      state_q, state_d;
  logic [10:0] width_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic [7:0]  color_d;
  logic        running_d, expired_d;
  logic        dec;
  logic [11:0] sum;
  logic [10:0] sat;

  // Width arithmetic is done 12 bits wide so a refill near full width saturates cleanly.
  assign dec = (state_q == StRun) && startOfFrame && (frame_cnt_q == FppLast);
  assign sum = {1'b0, barWidth} - {11'd0, dec} + (refill ? RefillAdd : 12'd0);
  assign sat = (sum > {1'b0, MaxW}) ? MaxW : sum[10:0];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= StIdle;
      barWidth      <= MaxW;
      barColor      <= NORMAL_COLOR;
      running       <= 1'b0;
      expired       <= 1'b0;
      frame_cnt_q   <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      barWidth      <= width_d;
      barColor      <= color_d;
      running       <= running_d;
      expired       <= expired_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    width_d       = barWidth;
    frame_cnt_d   = frame_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (start) begin
      state_d       = StRun;
      width_d       = MaxW;
      frame_cnt_d   = '0;
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StRun: begin
          if (startOfFrame) begin
            frame_cnt_d = (frame_cnt_q == FppLast) ? 16'd0 : frame_cnt_q + 16'd1;
          end
          if ({1'b0, barWidth} >= WarnW) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
          end else if (startOfFrame) begin
            if (blink_cnt_q == BlinkLast) begin
              blink_cnt_d   = '0;
              blink_phase_d = ~blink_phase_q;
            end else begin
              blink_cnt_d = blink_cnt_q + 16'd1;
            end
          end
          width_d = sat;
          // Expiry wins over a same-cycle pause request.
          if (sat == 11'd0) begin
            state_d = StExpired;
          end else if (pause) begin
            state_d = StPause;
          end
        end
        StPause: begin
          width_d = sat;
          if (!pause) begin
            state_d = StRun;
          end
        end
        StExpired: width_d = 11'd0;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    running_d = (state_d == StRun);
    expired_d = (state_d == StExpired) && (state_q != StExpired);
    unique case (state_d)
      StIdle:    color_d = NORMAL_COLOR;
      StExpired: color_d = WARN_COLOR;
      default:   color_d = (({1'b0, width_d} < WarnW) && blink_phase_d) ? WARN_COLOR : NORMAL_COLOR;
    endcase
  end

endmodule
